// File: rtl/csi_packet_parser.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : csi_packet_parser
// Purpose  : CSI-2 packet header decoder between the lane merger and the
//            RAW10 unpacker. Turns short packets into frame/line sync pulses,
//            strips the header from accepted long packets and forwards their
//            payload with valid/last/byte-enable.
// Options  : define CSI_PARSER_ECC_CHECK_EN to drop headers whose 6-bit
//            Hamming syndrome is nonzero (detect only, flagged on err_hdr_o).
// Revision : 1.0 - initial release
// ============================================================================
module csi_packet_parser #(
  parameter logic [1:0]  VC        = 2'd0,
  parameter logic [5:0]  ACCEPT_DT = 6'h2B,
  parameter logic [15:0] WC_MAX    = 16'd4096
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic [31:0] data_i,
  input  logic        data_valid_i,
  output logic [31:0] payload_o,
  output logic        payload_valid_o,
  output logic        payload_last_o,
  output logic [3:0]  payload_be_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic        line_start_o,
  output logic        in_frame_o,
  output logic [15:0] line_count_o,
  output logic        err_trunc_o,
  output logic        err_hdr_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PAYLOAD  = 2'd1,
    ST_WAIT_EOT = 2'd2
  } state_t;

  localparam logic [5:0] DT_FS = 6'h00;
  localparam logic [5:0] DT_FE = 6'h01;
  localparam logic [5:0] DT_LS = 6'h02;

  state_t      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] payload_q, payload_d;
  logic        pvalid_q, pvalid_d;
  logic        plast_q, plast_d;
  logic [3:0]  pbe_q, pbe_d;
  logic        fs_q, fs_d;
  logic        fe_q, fe_d;
  logic        ls_q, ls_d;
  logic        in_frame_q, in_frame_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic        err_trunc_q, err_trunc_d;
  logic        err_hdr_q, err_hdr_d;

  // Header field decode; only meaningful on the first word of a burst.
  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        ecc_err;

  assign hdr_vc = data_i[7:6];
  assign hdr_dt = data_i[5:0];
  assign hdr_wc = {data_i[23:16], data_i[15:8]};

`ifdef CSI_PARSER_ECC_CHECK_EN
  // Recompute the parity bits over the 24 header bits; any difference from
  // the transmitted ECC marks the header as untrustworthy.
  logic [5:0] ecc_calc;
  assign ecc_calc[0] = ^(data_i[23:0] & 24'hF12CB7);
  assign ecc_calc[1] = ^(data_i[23:0] & 24'hF2555B);
  assign ecc_calc[2] = ^(data_i[23:0] & 24'h749A6D);
  assign ecc_calc[3] = ^(data_i[23:0] & 24'hB8E38E);
  assign ecc_calc[4] = ^(data_i[23:0] & 24'hDF03F0);
  assign ecc_calc[5] = ^(data_i[23:0] & 24'hEFFC00);
  assign ecc_err     = |(ecc_calc ^ data_i[29:24]);
`else
  assign ecc_err     = 1'b0;
`endif

  // State and output registers; reset parks in WAIT_EOT so a burst that is
  // already in flight is discarded rather than mistaken for a header.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q     <= ST_WAIT_EOT;
      rem_q       <= '0;
      payload_q   <= '0;
      pvalid_q    <= 1'b0;
      plast_q     <= 1'b0;
      pbe_q       <= '0;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
      ls_q        <= 1'b0;
      in_frame_q  <= 1'b0;
      line_cnt_q  <= '0;
      err_trunc_q <= 1'b0;
      err_hdr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      payload_q   <= payload_d;
      pvalid_q    <= pvalid_d;
      plast_q     <= plast_d;
      pbe_q       <= pbe_d;
      fs_q        <= fs_d;
      fe_q        <= fe_d;
      ls_q        <= ls_d;
      in_frame_q  <= in_frame_d;
      line_cnt_q  <= line_cnt_d;
      err_trunc_q <= err_trunc_d;
      err_hdr_q   <= err_hdr_d;
    end
  end

  // Next-state and next-output decode: pulses default low, frame state holds.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    payload_d   = '0;
    pvalid_d    = 1'b0;
    plast_d     = 1'b0;
    pbe_d       = 4'h0;
    fs_d        = 1'b0;
    fe_d        = 1'b0;
    ls_d        = 1'b0;
    in_frame_d  = in_frame_q;
    line_cnt_d  = line_cnt_q;
    err_trunc_d = 1'b0;
    err_hdr_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (data_valid_i) begin
          // Every header ends in WAIT_EOT unless payload follows.
          state_d = ST_WAIT_EOT;
          if (ecc_err) begin
            err_hdr_d = 1'b1;
          end else if (hdr_vc == VC) begin
            if (hdr_dt < 6'h10) begin
              // Short packet: only FS/FE/LS carry meaning here.
              if (hdr_dt == DT_FS) begin
                fs_d       = 1'b1;
                in_frame_d = 1'b1;
                line_cnt_d = '0;
              end else if (hdr_dt == DT_FE) begin
                fe_d       = 1'b1;
                in_frame_d = 1'b0;
              end else if (hdr_dt == DT_LS) begin
                ls_d       = 1'b1;
              end
            end else if (hdr_wc > WC_MAX) begin
              err_hdr_d = 1'b1;
            end else if (hdr_dt == ACCEPT_DT) begin
              // A zero-length line still counts as a line.
              ls_d       = 1'b1;
              line_cnt_d = line_cnt_q + 16'd1;
              if (hdr_wc != 16'd0) begin
                state_d = ST_PAYLOAD;
                rem_d   = hdr_wc;
              end
            end
          end
        end
      end

      ST_PAYLOAD: begin
        if (data_valid_i) begin
          payload_d = data_i;
          pvalid_d  = 1'b1;
          if (rem_q <= 16'd4) begin
            // Bytes past the word count (CRC) are masked off or fall in
            // later words that WAIT_EOT swallows.
            plast_d = 1'b1;
            case (rem_q[2:0])
              3'd4:    pbe_d = 4'hF;
              3'd3:    pbe_d = 4'h7;
              3'd2:    pbe_d = 4'h3;
              default: pbe_d = 4'h1;
            endcase
            state_d = ST_WAIT_EOT;
          end else begin
            pbe_d = 4'hF;
            rem_d = rem_q - 16'd4;
          end
        end else begin
          // Burst ended early: the unpacker sees valid drop without last.
          err_trunc_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      ST_WAIT_EOT: begin
        if (!data_valid_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_WAIT_EOT;
      end
    endcase
  end

  assign payload_o       = payload_q;
  assign payload_valid_o = pvalid_q;
  assign payload_last_o  = plast_q;
  assign payload_be_o    = pbe_q;
  assign frame_start_o   = fs_q;
  assign frame_end_o     = fe_q;
  assign line_start_o    = ls_q;
  assign in_frame_o      = in_frame_q;
  assign line_count_o    = line_cnt_q;
  assign err_trunc_o     = err_trunc_q;
  assign err_hdr_o       = err_hdr_q;

endmodule
`default_nettype wire

// File: tb/tb_csi_packet_parser.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_csi_packet_parser
// Purpose  : Directed, table-driven bench for csi_packet_parser. Each row is
//            one clock: the inputs driven for that cycle and the full set of
//            registered outputs expected just after the following edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csi_packet_parser;

  logic        clk_i = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_i = '0;
  logic        data_valid_i = 1'b0;
  logic [31:0] payload_o;
  logic        payload_valid_o;
  logic        payload_last_o;
  logic [3:0]  payload_be_o;
  logic        frame_start_o;
  logic        frame_end_o;
  logic        line_start_o;
  logic        in_frame_o;
  logic [15:0] line_count_o;
  logic        err_trunc_o;
  logic        err_hdr_o;

  always #5 clk_i = ~clk_i;

  csi_packet_parser dut (
    .clk_i          (clk_i),
    .reset          (reset),
    .data_i         (data_i),
    .data_valid_i   (data_valid_i),
    .payload_o      (payload_o),
    .payload_valid_o(payload_valid_o),
    .payload_last_o (payload_last_o),
    .payload_be_o   (payload_be_o),
    .frame_start_o  (frame_start_o),
    .frame_end_o    (frame_end_o),
    .line_start_o   (line_start_o),
    .in_frame_o     (in_frame_o),
    .line_count_o   (line_count_o),
    .err_trunc_o    (err_trunc_o),
    .err_hdr_o      (err_hdr_o)
  );

  // Expected outputs packed as
  // {payload, valid, last, be, fs, fe, ls, in_frame, line_count, trunc, hdr}
  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] d;
    logic [60:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [60:0] act;
  vec_t tbl[$];

  // CSI-2 header ECC, written out bit by bit from the parity equations.
  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  function automatic logic [31:0] hdr(input logic [7:0] di, input logic [15:0] wc);
    return {2'b00, ecc6({wc, di}), wc, di};
  endfunction

  // Fully specified expectation.
  function automatic logic [60:0] ex(input logic [31:0] p, input logic pv, input logic pl,
                                     input logic [3:0] be, input logic fs, input logic fe,
                                     input logic ls, input logic inf, input logic [15:0] lc,
                                     input logic et, input logic eh);
    return {p, pv, pl, be, fs, fe, ls, inf, lc, et, eh};
  endfunction

  // Quiet cycle: no pulses, no payload, frame state as given.
  function automatic logic [60:0] qt(input logic inf, input logic [15:0] lc);
    return ex(32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, inf, lc, 1'b0, 1'b0);
  endfunction

  function automatic vec_t mk(input logic rst, input logic v, input logic [31:0] d,
                              input logic [60:0] e);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.exp = e;
    return t;
  endfunction

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk_i);
    reset        = t.rst;
    data_valid_i = t.v;
    data_i       = t.d;
    @(posedge clk_i);
    #1;
    act = {payload_o, payload_valid_o, payload_last_o, payload_be_o, frame_start_o,
           frame_end_o, line_start_o, in_frame_o, line_count_o, err_trunc_o, err_hdr_o};
    checks++;
    if (act !== t.exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, t.exp);
    end
  endtask

  initial begin
    // Reset and FS.
    tbl.push_back(mk(1, 0, 32'h0, qt(0, 0)));
    tbl.push_back(mk(1, 0, 32'h0, qt(0, 0)));
    tbl.push_back(mk(0, 0, 32'h0, qt(0, 0)));
    tbl.push_back(mk(0, 1, hdr(8'h00, 16'h0000), ex(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 32'h0, qt(1, 0)));
    // RAW10 line, WC=10: three words, last with be=3, CRC word dropped.
    tbl.push_back(mk(0, 1, hdr(8'h2B, 16'h000A), ex(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 1, 32'h03020100, ex(32'h03020100, 1, 0, 4'hF, 0, 0, 0, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 1, 32'h07060504, ex(32'h07060504, 1, 0, 4'hF, 0, 0, 0, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 1, 32'hCCCC0908, ex(32'hCCCC0908, 1, 1, 4'h3, 0, 0, 0, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 1, 32'hDEADBEEF, qt(1, 1)));
    tbl.push_back(mk(0, 0, 32'h0, qt(1, 1)));
    // Truncated WC=8 line, then FE still decoded.
    tbl.push_back(mk(0, 1, hdr(8'h2B, 16'h0008), ex(0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0)));
    tbl.push_back(mk(0, 1, 32'h11223344, ex(32'h11223344, 1, 0, 4'hF, 0, 0, 0, 1, 2, 0, 0)));
    tbl.push_back(mk(0, 0, 32'h0, ex(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0)));
    tbl.push_back(mk(0, 1, hdr(8'h01, 16'h0000), ex(0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0)));
    tbl.push_back(mk(0, 0, 32'h0, qt(0, 2)));
    // Foreign VC ignored entirely.
    tbl.push_back(mk(0, 1, hdr(8'h6B, 16'h0004), qt(0, 2)));
    tbl.push_back(mk(0, 1, 32'h55555555, qt(0, 2)));
    tbl.push_back(mk(0, 0, 32'h0, qt(0, 2)));
    // Oversized WC flagged.
    tbl.push_back(mk(0, 1, hdr(8'h2B, 16'h2000), ex(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1)));
    tbl.push_back(mk(0, 1, 32'h12345678, qt(0, 2)));
    tbl.push_back(mk(0, 0, 32'h0, qt(0, 2)));
    // FE while not in frame still pulses.
    tbl.push_back(mk(0, 1, hdr(8'h01, 16'h0000), ex(0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0)));
    tbl.push_back(mk(0, 0, 32'h0, qt(0, 2)));
    // FS clears count; LS short; zero-length long line counts.
    tbl.push_back(mk(0, 1, hdr(8'h00, 16'h0000), ex(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 32'h0, qt(1, 0)));
    tbl.push_back(mk(0, 1, hdr(8'h02, 16'h0000), ex(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 32'h0, qt(1, 0)));
    tbl.push_back(mk(0, 1, hdr(8'h2B, 16'h0000), ex(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 0, 32'h0, qt(1, 1)));
    // FS while already in frame.
    tbl.push_back(mk(0, 1, hdr(8'h00, 16'h0000), ex(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 32'h0, qt(1, 0)));
    // WC=4: single full last word.
    tbl.push_back(mk(0, 1, hdr(8'h2B, 16'h0004), ex(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 1, 32'hA5A5A5A5, ex(32'hA5A5A5A5, 1, 1, 4'hF, 0, 0, 0, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 0, 32'h0, qt(1, 1)));
    // WC=5: last word be=1.
    tbl.push_back(mk(0, 1, hdr(8'h2B, 16'h0005), ex(0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0)));
    tbl.push_back(mk(0, 1, 32'h01010101, ex(32'h01010101, 1, 0, 4'hF, 0, 0, 0, 1, 2, 0, 0)));
    tbl.push_back(mk(0, 1, 32'h02020202, ex(32'h02020202, 1, 1, 4'h1, 0, 0, 0, 1, 2, 0, 0)));
    tbl.push_back(mk(0, 0, 32'h0, qt(1, 2)));
    // WC=7: last word be=7.
    tbl.push_back(mk(0, 1, hdr(8'h2B, 16'h0007), ex(0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0)));
    tbl.push_back(mk(0, 1, 32'h0A0B0C0D, ex(32'h0A0B0C0D, 1, 0, 4'hF, 0, 0, 0, 1, 3, 0, 0)));
    tbl.push_back(mk(0, 1, 32'h0E0F1011, ex(32'h0E0F1011, 1, 1, 4'h7, 0, 0, 0, 1, 3, 0, 0)));
    tbl.push_back(mk(0, 0, 32'h0, qt(1, 3)));
    // Other long DT silently dropped.
    tbl.push_back(mk(0, 1, hdr(8'h2A, 16'h0008), qt(1, 3)));
    tbl.push_back(mk(0, 1, 32'h99999999, qt(1, 3)));
    tbl.push_back(mk(0, 0, 32'h0, qt(1, 3)));
    // WC boundary: 4097 flagged, 4096 accepted (then truncated at once).
    tbl.push_back(mk(0, 1, hdr(8'h2B, 16'h1001), ex(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1)));
    tbl.push_back(mk(0, 0, 32'h0, qt(1, 3)));
    tbl.push_back(mk(0, 1, hdr(8'h2B, 16'h1000), ex(0, 0, 0, 0, 0, 0, 1, 1, 4, 0, 0)));
    tbl.push_back(mk(0, 0, 32'h0, ex(0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 0)));
    tbl.push_back(mk(0, 0, 32'h0, qt(1, 4)));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset lands on the 2nd payload word of a WC=16 line and is released
    // mid-burst: nothing may come out until valid drops.
    apply(mk(0, 1, hdr(8'h2B, 16'h0010), ex(0, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0)), "rst_hdr");
    apply(mk(0, 1, 32'hF0F0F0F0, ex(32'hF0F0F0F0, 1, 0, 4'hF, 0, 0, 0, 1, 5, 0, 0)), "rst_w1");
    apply(mk(1, 1, 32'hE1E1E1E1, qt(0, 0)), "rst_w2");
    apply(mk(0, 1, 32'hD2D2D2D2, qt(0, 0)), "rst_w3");
    apply(mk(0, 1, 32'hC3C3C3C3, qt(0, 0)), "rst_w4");
    apply(mk(0, 0, 32'h0, qt(0, 0)), "rst_eot");
    apply(mk(0, 1, hdr(8'h00, 16'h0000), ex(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0)), "rst_fs");
    apply(mk(0, 0, 32'h0, qt(1, 0)), "rst_idle");

`ifdef CSI_PARSER_ECC_CHECK_EN
    // FS header with ECC bit 0 flipped: flagged and dropped.
    apply(mk(0, 1, hdr(8'h00, 16'h0000) ^ 32'h0100_0000,
             ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1)), "ecc_fs");
    apply(mk(0, 0, 32'h0, qt(1, 0)), "ecc_idle");
    // Corrupted FE must not close the frame.
    apply(mk(0, 1, hdr(8'h01, 16'h0000) ^ 32'h0000_0100,
             ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1)), "ecc_fe");
    apply(mk(0, 0, 32'h0, qt(1, 0)), "ecc_idle2");
    // Correctly protected long header still accepted.
    apply(mk(0, 1, hdr(8'h2B, 16'h0004), ex(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0)), "ecc_ok");
    apply(mk(0, 1, 32'h76543210, ex(32'h76543210, 1, 1, 4'hF, 0, 0, 0, 1, 1, 0, 0)), "ecc_ok_w");
    apply(mk(0, 0, 32'h0, qt(1, 1)), "ecc_idle3");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
